// File: rtl/cdd_pkg.sv
// cdd_pkg: shared FSM states, protocol codes and frame checksum for the CDD host link
package cdd_pkg;
  localparam int CW = 16;
  typedef enum logic [2:0] {IDLE, IRQ, TX_PUT, TX_WH, TX_WL, RX_WH, RX_WL, DONE} state_t;
  localparam logic [3:0] STOPPED = 4'd0, PLAYING = 4'd1, READTOC = 4'd9;
  localparam logic [3:0] NOP = 4'd0, STOP = 4'd1, TOC = 4'd2, PLAY = 4'd3, SEEK = 4'd4, PAUSE = 4'd6,
                         RESUME = 4'd7, FFW = 4'd8, REW = 4'd9, CLOSE = 4'd12, OPEN = 4'd13;
  // Frames are passed zero-extended to the 15-nibble maximum; n is the real length.
  function automatic logic [3:0] csum(input logic [59:0] f, input int n);
    logic [7:0] s;
    s = '0;
    for (int i = 0; i < 14; i++) if (i < n - 1) s = s + {4'b0, f[i*4 +: 4]};
    return ~s[3:0];
  endfunction
endpackage

// File: rtl/cdd_tick_gen.sv
// cdd_tick_gen: MCU tick divider and IRQ period counter with 64/75 Hz select
// Ports: clk_sys_i/reset_i; fast_rate_i selects the play period;
// tick_o one-clk tick, irq_o one-clk period expiry (on a tick), half_o current period / 2.
module cdd_tick_gen import cdd_pkg::*; #(
  parameter int CLK_DIV      = 192,
  parameter int IRQ_PER_IDLE = 3906,
  parameter int IRQ_PER_PLAY = 3333
) (
  input  logic          clk_sys_i,
  input  logic          reset_i,
  input  logic          fast_rate_i,
  output logic          tick_o,
  output logic          irq_o,
  output logic [CW-1:0] half_o
);
  logic [CW-1:0] div_q, div_d, cnt_q, cnt_d, per;
  assign per    = fast_rate_i ? CW'(IRQ_PER_PLAY) : CW'(IRQ_PER_IDLE);
  assign half_o = per >> 1;
  assign tick_o = div_q == CW'(CLK_DIV - 1);
  // >= so a switch to the shorter period mid-count still wraps promptly
  assign irq_o  = tick_o && cnt_q >= per - 1'b1;
  always_comb begin
    div_d = tick_o ? '0 : div_q + 1'b1;
    cnt_d = irq_o ? '0 : tick_o ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk_sys_i) begin
    if (reset_i) begin
      div_q <= '0;
      cnt_q <= '0;
    end else begin
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/cdd_link.sv
// cdd_link: drive-side emulator of the CDD nibble-serial host link
// Ports: clk_sys/reset; host side hock, cdd_din in, cdck, cdd_dout, cdd_nirq out;
// core side fast_rate, status_in, status_latch in, cmd_data, cmd_valid, cmd_err, timeout out.
module cdd_link import cdd_pkg::*; #(
  parameter int CLK_DIV       = 192,
  parameter int NIBBLES       = 10,
  parameter int IRQ_PER_IDLE  = 3906,
  parameter int IRQ_PER_PLAY  = 3333,
  parameter int TIMEOUT_TICKS = 64,
  parameter int CHECKSUM      = 1
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic                 hock,
  input  logic [3:0]           cdd_din,
  output logic                 cdck,
  output logic [3:0]           cdd_dout,
  output logic                 cdd_nirq,
  input  logic                 fast_rate,
  input  logic [4*NIBBLES-1:0] status_in,
  input  logic                 status_latch,
  output logic [4*NIBBLES-1:0] cmd_data,
  output logic                 cmd_valid,
  output logic                 cmd_err,
  output logic                 timeout
);
  localparam int FW = 4 * NIBBLES;
  localparam logic [3:0] LAST = 4'(NIBBLES - 1);
  logic tick, irq_req, rise, fall, waiting, load, rx_ok;
  logic [CW-1:0] half, wait_q, wait_d;
  state_t state_q, state_d;
  logic [3:0] idx_q, idx_d, dout_q, dout_d, tx_nib;
  logic hock_prev_q, latch_prev_q, pending_q;
  logic [FW-1:0] shadow_q, active_q, buf_q, buf_d, cmd_q, cmd_d;
  logic cdck_q, cdck_d, nirq_q, nirq_d, valid_q, valid_d, err_q, err_d, tmo_q, tmo_d;
  cdd_tick_gen #(
    .CLK_DIV(CLK_DIV), .IRQ_PER_IDLE(IRQ_PER_IDLE), .IRQ_PER_PLAY(IRQ_PER_PLAY)
  ) u_tick (
    .clk_sys_i(clk_sys), .reset_i(reset), .fast_rate_i(fast_rate),
    .tick_o(tick), .irq_o(irq_req), .half_o(half)
  );
  assign rise    = tick & hock & ~hock_prev_q;
  assign fall    = tick & ~hock & hock_prev_q;
  assign waiting = state_q inside {TX_WH, TX_WL, RX_WH, RX_WL};
  assign tx_nib  = (CHECKSUM != 0 && idx_q == LAST) ? csum(60'(active_q), NIBBLES) : active_q[{idx_q, 2'b00} +: 4];
  assign rx_ok   = CHECKSUM == 0 || csum(60'(buf_q), NIBBLES) == buf_q[FW-1 -: 4];
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    cmd_d   = cmd_q;
    cdck_d  = cdck_q;
    nirq_d  = nirq_q;
    dout_d  = dout_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    tmo_d   = 1'b0;
    load    = 1'b0;
    if (tick) begin
      case (state_q)
        IDLE: begin
          cdck_d = 1'b1;
          if (irq_req) begin
            state_d = IRQ;
            nirq_d  = 1'b0;
            load    = 1'b1;
          end
        end
        IRQ: begin
          if (!hock) begin
            nirq_d  = 1'b1;
            idx_d   = '0;
            state_d = TX_PUT;
          end else if (wait_q == half - 1'b1) begin
            nirq_d  = 1'b1;
            state_d = IDLE;
          end
        end
        TX_PUT: begin
          dout_d  = tx_nib;
          cdck_d  = 1'b0;
          state_d = TX_WH;
        end
        TX_WH: begin
          if (rise) begin
            cdck_d  = 1'b1;
            idx_d   = idx_q == LAST ? '0 : idx_q;
            state_d = idx_q == LAST ? RX_WH : TX_WL;
          end
        end
        TX_WL: begin
          if (fall) begin
            idx_d   = idx_q + 1'b1;
            state_d = TX_PUT;
          end
        end
        RX_WH: begin
          if (rise) begin
            buf_d[{idx_q, 2'b00} +: 4] = cdd_din;
            cdck_d  = 1'b1;
            state_d = RX_WL;
          end
        end
        RX_WL: begin
          if (fall) begin
            cdck_d  = 1'b0;
            idx_d   = idx_q == LAST ? idx_q : idx_q + 1'b1;
            state_d = idx_q == LAST ? DONE : RX_WH;
          end
        end
        DONE: begin
          cmd_d   = buf_q;
          valid_d = rx_ok;
          err_d   = !rx_ok;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
      if (waiting && state_d == state_q && wait_q == CW'(TIMEOUT_TICKS - 1)) begin
        tmo_d   = 1'b1;
        cdck_d  = 1'b1;
        state_d = IDLE;
      end
    end
    // Wait counter restarts on every state change, so each handshake phase gets its own budget
    wait_d = !tick ? wait_q : state_d != state_q ? '0 : wait_q + 1'b1;
  end
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      wait_q      <= '0;
      buf_q       <= '0;
      cmd_q       <= '0;
      cdck_q      <= 1'b1;
      nirq_q      <= 1'b1;
      dout_q      <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      tmo_q       <= 1'b0;
      hock_prev_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wait_q      <= wait_d;
      buf_q       <= buf_d;
      cmd_q       <= cmd_d;
      cdck_q      <= cdck_d;
      nirq_q      <= nirq_d;
      dout_q      <= dout_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      tmo_q       <= tmo_d;
      hock_prev_q <= tick ? hock : hock_prev_q;
    end
  end
  // Status is double-buffered: a latch edge lands in the shadow, which only becomes
  // active at IRQ entry so a frame in flight never mixes old and new nibbles.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      latch_prev_q <= 1'b0;
      pending_q    <= 1'b0;
      shadow_q     <= '0;
      active_q     <= '0;
    end else begin
      latch_prev_q <= status_latch;
      if (load && pending_q) begin
        active_q  <= shadow_q;
        pending_q <= 1'b0;
      end
      if (status_latch && !latch_prev_q) begin
        shadow_q  <= status_in;
        pending_q <= 1'b1;
      end
    end
  end
  assign cdck      = cdck_q;
  assign cdd_dout  = dout_q;
  assign cdd_nirq  = nirq_q;
  assign cmd_data  = cmd_q;
  assign cmd_valid = valid_q;
  assign cmd_err   = err_q;
  assign timeout   = tmo_q;
endmodule
